// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one multi-cycle FP adder between two valid/ready requesters.
// Optional FPA_ZERO_BYPASS_EN: adds with a zero operand are answered from IDLE without the adder.
module fp_add_arbiter #(
  parameter int ADD_LATENCY = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic [0:1]  req_valid,
  output logic [0:1]  req_ready,
  input  logic [0:63] req_op_a,
  input  logic [0:63] req_op_b,
  output logic [0:1]  rsp_valid,
  input  logic [0:1]  rsp_ready,
  output logic [0:31] rsp_data,
  output logic [0:3]  rsp_status,
  output logic        busy,
  output logic        add_rst_n,
  output logic [0:31] add_op_a,
  output logic [0:31] add_op_b,
  input  logic [0:31] add_data,
  input  logic [0:3]  add_status
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             owner;
  logic             grant;
  logic             win;
  logic             bypass;
  logic             rsp_accept;
  logic [CNT_W-1:0] cnt;
  logic [0:31]      win_a;
  logic [0:31]      win_b;
  logic [0:31]      bypass_data;

  // Arbitration: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    grant = (state == IDLE) && (req_valid != 2'b00);
    if (req_valid[0] && req_valid[1]) begin
      win = rr_ptr;
    end else begin
      win = req_valid[1];
    end
    req_ready[0] = grant && !win;
    req_ready[1] = grant && win;
    win_a = win ? req_op_a[32:63] : req_op_a[0:31];
    win_b = win ? req_op_b[32:63] : req_op_b[0:31];
  end

`ifdef FPA_ZERO_BYPASS_EN
  always_comb begin
    bypass      = (win_a == 32'h0) || (win_b == 32'h0);
    bypass_data = (win_a == 32'h0) ? win_b : win_a;
  end
`else
  always_comb begin
    bypass      = 1'b0;
    bypass_data = win_b;
  end
`endif

  assign rsp_accept = (state == RESPOND) && rsp_ready[owner];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = bypass ? RESPOND : RUN;
      RUN:     if (cnt == CNT_W'(ADD_LATENCY - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESPOND;
      RESPOND: if (rsp_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid    = 2'b00;
    rsp_valid[0] = (state == RESPOND) && !owner;
    rsp_valid[1] = (state == RESPOND) && owner;
  end

  // Control registers; add_rst_n is registered so the adder reset never glitches.
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      add_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      add_rst_n <= (state_nxt == RUN);
      if (grant) begin
        owner  <= win;
        rr_ptr <= ~win;
        cnt    <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Operand and result registers, held stable between their load points.
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      add_op_a   <= '0;
      add_op_b   <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
    end else begin
      if (grant) begin
        add_op_a <= win_a;
        add_op_b <= win_b;
        if (bypass) begin
          rsp_data   <= bypass_data;
          rsp_status <= '0;
        end
      end
      if (state == CAPTURE) begin
        rsp_data   <= add_data;
        rsp_status <= add_status;
      end
    end
  end

endmodule
